// File: rtl/instr_encoder_pkg.sv
// Shared CPU definitions: op indices (decoder bit order), opcodes, functs, COP0 codes.
package instr_encoder_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned NUM_OPS = 54;

    // Op indices, identical to the decoder's one-hot out_data bit positions
    localparam logic [OP_W-1:0]
        OP_ADD  = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_SUBU  = 6'd3,
        OP_AND  = 6'd4,  OP_OR    = 6'd5,  OP_XOR   = 6'd6,  OP_NOR   = 6'd7,
        OP_SLT  = 6'd8,  OP_SLTU  = 6'd9,  OP_SLL   = 6'd10, OP_SRL   = 6'd11,
        OP_SRA  = 6'd12, OP_SLLV  = 6'd13, OP_SRLV  = 6'd14, OP_SRAV  = 6'd15,
        OP_JR   = 6'd16, OP_ADDI  = 6'd17, OP_ADDIU = 6'd18, OP_ANDI  = 6'd19,
        OP_ORI  = 6'd20, OP_XORI  = 6'd21, OP_LW    = 6'd22, OP_SW    = 6'd23,
        OP_BEQ  = 6'd24, OP_BNE   = 6'd25, OP_SLTI  = 6'd26, OP_SLTIU = 6'd27,
        OP_LUI  = 6'd28, OP_J     = 6'd29, OP_JAL   = 6'd30, OP_DIV   = 6'd31,
        OP_DIVU = 6'd32, OP_MULT  = 6'd33, OP_MULTU = 6'd34, OP_BGEZ  = 6'd35,
        OP_JALR = 6'd36, OP_LBU   = 6'd37, OP_LHU   = 6'd38, OP_LB    = 6'd39,
        OP_LH   = 6'd40, OP_SB    = 6'd41, OP_SH    = 6'd42, OP_BREAK = 6'd43,
        OP_SYSCALL = 6'd44, OP_ERET = 6'd45, OP_MFHI = 6'd46, OP_MFLO  = 6'd47,
        OP_MTHI = 6'd48, OP_MTLO  = 6'd49, OP_MFC0  = 6'd50, OP_MTC0  = 6'd51,
        OP_CLZ  = 6'd52, OP_TEQ   = 6'd53;

    // Primary opcodes
    localparam logic [5:0]
        OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02, OPC_JAL   = 6'h03,
        OPC_BEQ     = 6'h04, OPC_BNE    = 6'h05, OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09,
        OPC_SLTI    = 6'h0a, OPC_SLTIU  = 6'h0b, OPC_ANDI = 6'h0c, OPC_ORI   = 6'h0d,
        OPC_XORI    = 6'h0e, OPC_LUI    = 6'h0f, OPC_COP0 = 6'h10, OPC_SPECIAL2 = 6'h1c,
        OPC_LB      = 6'h20, OPC_LH     = 6'h21, OPC_LW   = 6'h23, OPC_LBU   = 6'h24,
        OPC_LHU     = 6'h25, OPC_SB     = 6'h28, OPC_SH   = 6'h29, OPC_SW    = 6'h2b;

    // Function codes
    localparam logic [5:0]
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09,
        FN_SYSCALL = 6'h0c, FN_BREAK = 6'h0d, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
        FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
        FN_DIV  = 6'h1a, FN_DIVU = 6'h1b, FN_ADD   = 6'h20, FN_ADDU  = 6'h21,
        FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
        FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2a, FN_SLTU  = 6'h2b,
        FN_TEQ  = 6'h34, FN_CLZ  = 6'h20, FN_ERET  = 6'h18;

    // COP0 rs codes and REGIMM rt code
    localparam logic [REG_W-1:0] CP0_MF = 5'b00000, CP0_MT = 5'b00100, CP0_CO = 5'b10000;
    localparam logic [REG_W-1:0] RT_BGEZ = 5'b00001;
    localparam logic [REG_W-1:0] R0 = 5'd0;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] shamt;
        logic [IMM_W-1:0] imm;
        logic [TGT_W-1:0] target;
    } instr_req_t;

    function automatic logic [INSTR_W-1:0] r_word(logic [REG_W-1:0] rs, logic [REG_W-1:0] rt,
                                                  logic [REG_W-1:0] rd, logic [REG_W-1:0] sh,
                                                  logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [INSTR_W-1:0] i_word(logic [5:0] opc, logic [REG_W-1:0] rs,
                                                  logic [REG_W-1:0] rt, logic [IMM_W-1:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-to-IMEM request/word bus around the instruction encoder.
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      in_op;
    logic [REG_W-1:0]     in_rs;
    logic [REG_W-1:0]     in_rt;
    logic [REG_W-1:0]     in_rd;
    logic [REG_W-1:0]     in_shamt;
    logic [IMM_W-1:0]     in_imm;
    logic [TGT_W-1:0]     in_target;
    logic                 addr_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 err_op;
    logic [OP_W-1:0]      err_op_id;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
               addr_clr, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_op, err_op_id
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
               addr_clr, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_op, err_op_id
    );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational op index + operand fields -> 32-bit MIPS word, with illegal-op flag.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  instr_req_t          req,
    output logic [INSTR_W-1:0]  instr_c,
    output logic                illegal_c
);
    logic [REG_W-1:0] rs, rt, rd, sh;

    assign rs = req.rs;
    assign rt = req.rt;
    assign rd = req.rd;
    assign sh = req.shamt;

    // Field assembly per op; unused fields forced to zero
    always_comb begin
        instr_c   = '0;
        illegal_c = 1'b0;
        case (req.op)
            OP_ADD:     instr_c = r_word(rs, rt, rd, sh, FN_ADD);
            OP_ADDU:    instr_c = r_word(rs, rt, rd, sh, FN_ADDU);
            OP_SUB:     instr_c = r_word(rs, rt, rd, sh, FN_SUB);
            OP_SUBU:    instr_c = r_word(rs, rt, rd, sh, FN_SUBU);
            OP_AND:     instr_c = r_word(rs, rt, rd, sh, FN_AND);
            OP_OR:      instr_c = r_word(rs, rt, rd, sh, FN_OR);
            OP_XOR:     instr_c = r_word(rs, rt, rd, sh, FN_XOR);
            OP_NOR:     instr_c = r_word(rs, rt, rd, sh, FN_NOR);
            OP_SLT:     instr_c = r_word(rs, rt, rd, sh, FN_SLT);
            OP_SLTU:    instr_c = r_word(rs, rt, rd, sh, FN_SLTU);
            OP_SLL:     instr_c = r_word(R0, rt, rd, sh, FN_SLL);
            OP_SRL:     instr_c = r_word(R0, rt, rd, sh, FN_SRL);
            OP_SRA:     instr_c = r_word(R0, rt, rd, sh, FN_SRA);
            OP_SLLV:    instr_c = r_word(rs, rt, rd, sh, FN_SLLV);
            OP_SRLV:    instr_c = r_word(rs, rt, rd, sh, FN_SRLV);
            OP_SRAV:    instr_c = r_word(rs, rt, rd, sh, FN_SRAV);
            OP_JR:      instr_c = r_word(rs, R0, R0, R0, FN_JR);
            OP_JALR:    instr_c = r_word(rs, R0, rd, sh, FN_JALR);
            OP_MTHI:    instr_c = r_word(rs, R0, R0, R0, FN_MTHI);
            OP_MTLO:    instr_c = r_word(rs, R0, R0, R0, FN_MTLO);
            OP_MFHI:    instr_c = r_word(R0, R0, rd, R0, FN_MFHI);
            OP_MFLO:    instr_c = r_word(R0, R0, rd, R0, FN_MFLO);
            OP_MULT:    instr_c = r_word(rs, rt, R0, R0, FN_MULT);
            OP_MULTU:   instr_c = r_word(rs, rt, R0, R0, FN_MULTU);
            OP_DIV:     instr_c = r_word(rs, rt, R0, R0, FN_DIV);
            OP_DIVU:    instr_c = r_word(rs, rt, R0, R0, FN_DIVU);
            OP_BREAK:   instr_c = r_word(R0, R0, R0, R0, FN_BREAK);
            OP_SYSCALL: instr_c = r_word(R0, R0, R0, R0, FN_SYSCALL);
            OP_TEQ:     instr_c = r_word(rs, rt, R0, R0, FN_TEQ);
            OP_ADDI:    instr_c = i_word(OPC_ADDI, rs, rt, req.imm);
            OP_ADDIU:   instr_c = i_word(OPC_ADDIU, rs, rt, req.imm);
            OP_ANDI:    instr_c = i_word(OPC_ANDI, rs, rt, req.imm);
            OP_ORI:     instr_c = i_word(OPC_ORI, rs, rt, req.imm);
            OP_XORI:    instr_c = i_word(OPC_XORI, rs, rt, req.imm);
            OP_LW:      instr_c = i_word(OPC_LW, rs, rt, req.imm);
            OP_SW:      instr_c = i_word(OPC_SW, rs, rt, req.imm);
            OP_BEQ:     instr_c = i_word(OPC_BEQ, rs, rt, req.imm);
            OP_BNE:     instr_c = i_word(OPC_BNE, rs, rt, req.imm);
            OP_SLTI:    instr_c = i_word(OPC_SLTI, rs, rt, req.imm);
            OP_SLTIU:   instr_c = i_word(OPC_SLTIU, rs, rt, req.imm);
            OP_LUI:     instr_c = i_word(OPC_LUI, rs, rt, req.imm);
            OP_LB:      instr_c = i_word(OPC_LB, rs, rt, req.imm);
            OP_LBU:     instr_c = i_word(OPC_LBU, rs, rt, req.imm);
            OP_LH:      instr_c = i_word(OPC_LH, rs, rt, req.imm);
            OP_LHU:     instr_c = i_word(OPC_LHU, rs, rt, req.imm);
            OP_SB:      instr_c = i_word(OPC_SB, rs, rt, req.imm);
            OP_SH:      instr_c = i_word(OPC_SH, rs, rt, req.imm);
            OP_BGEZ:    instr_c = i_word(OPC_REGIMM, rs, RT_BGEZ, req.imm);
            OP_J:       instr_c = {OPC_J, req.target};
            OP_JAL:     instr_c = {OPC_JAL, req.target};
            OP_ERET:    instr_c = {OPC_COP0, CP0_CO, 15'd0, FN_ERET};
            OP_MFC0:    instr_c = {OPC_COP0, CP0_MF, rt, rd, 11'd0};
            OP_MTC0:    instr_c = {OPC_COP0, CP0_MT, rt, rd, 11'd0};
            OP_CLZ:     instr_c = {OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_CLZ};
            default:    illegal_c = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: encodes requests and streams tagged words to IMEM through a 2-entry queue.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
)(
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = 2;

    instr_req_t          req;
    logic [INSTR_W-1:0]  word_c;
    logic                illegal_c;
    logic                accept, push, pop;
    logic [ADDR_W-1:0]   addr_cnt, tag_c, addr_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                head_new, head_from_tail, tail_new;
    logic [INSTR_W-1:0]  tail_instr;
    logic [ADDR_W-1:0]   tail_addr;

    assign req = '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                   shamt: bus.in_shamt, imm: bus.in_imm, target: bus.in_target};

    instr_field_pack u_pack (
        .req       (req),
        .instr_c   (word_c),
        .illegal_c (illegal_c)
    );

    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & ~illegal_c;
    assign pop    = bus.out_valid & bus.out_ready;
    assign tag_c  = bus.addr_clr ? BASE_ADDR : addr_cnt;

    // Counter: a same-cycle push sees the reloaded base and steps past it
    always_comb begin
        addr_nxt = addr_cnt;
        if (push)
            addr_nxt = tag_c + ADDR_W'(4);
        else if (bus.addr_clr)
            addr_nxt = BASE_ADDR;
    end

    // Queue control: head is the output register, tail is the second slot
    always_comb begin
        count_nxt      = count;
        head_new       = 1'b0;
        head_from_tail = 1'b0;
        tail_new       = 1'b0;
        case ({push, pop})
            2'b10: begin
                count_nxt = count + CNT_W'(1);
                if (count == CNT_W'(0)) head_new = 1'b1;
                else                    tail_new = 1'b1;
            end
            2'b01: begin
                count_nxt      = count - CNT_W'(1);
                head_from_tail = (count == CNT_W'(2));
            end
            2'b11: begin
                if (count == CNT_W'(1)) begin
                    head_new = 1'b1;
                end else begin
                    head_from_tail = 1'b1;
                    tail_new       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Occupancy and registered handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            count         <= count_nxt;
            bus.in_ready  <= (count_nxt != CNT_W'(2));
            bus.out_valid <= (count_nxt != CNT_W'(0));
        end
    end

    // Queue data; head only changes on pop or on push into an empty queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_instr <= '0;
            bus.out_addr  <= BASE_ADDR;
            tail_instr    <= '0;
            tail_addr     <= BASE_ADDR;
        end else begin
            if (head_new) begin
                bus.out_instr <= word_c;
                bus.out_addr  <= tag_c;
            end else if (head_from_tail) begin
                bus.out_instr <= tail_instr;
                bus.out_addr  <= tail_addr;
            end
            if (tail_new) begin
                tail_instr <= word_c;
                tail_addr  <= tag_c;
            end
        end
    end

    // Address counter and sticky illegal-op capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt      <= BASE_ADDR;
            bus.err_op    <= 1'b0;
            bus.err_op_id <= '0;
        end else begin
            addr_cnt <= addr_nxt;
            if (accept && illegal_c) begin
                bus.err_op <= 1'b1;
                if (!bus.err_op) bus.err_op_id <= bus.in_op;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized round trip.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(32)) bus_a ();
    instr_encoder_if #(.ADDR_W(4))  bus_b ();

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0))  dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    instr_encoder #(.ADDR_W(4),  .BASE_ADDR(4'd12))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    localparam logic [31:0] M_RS = 32'h03E0_0000, M_RT = 32'h001F_0000, M_RD = 32'h0000_F800;
    localparam logic [31:0] M_SH = 32'h0000_07C0, M_LO = 32'h03FF_FFFF;
    localparam logic [31:0] M_R  = M_RS | M_RT | M_RD | M_SH;

    int compared = 0;
    int mismatched = 0;

    // Op table: cls 0=R layout, 1=I layout, 2=J layout; word = fixed | (raw & keep)
    int          cls_t   [54];
    logic [31:0] fixed_t [54];
    logic [31:0] keep_t  [54];

    typedef struct { logic [31:0] instr; logic [31:0] addr; int op; } exp_t;
    exp_t        expq[$];
    logic [31:0] m_addr;
    logic        m_err;
    logic [5:0]  m_err_id;
    int          b_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int c, input logic [31:0] f, input logic [31:0] k);
        cls_t[i] = c; fixed_t[i] = f; keep_t[i] = k;
    endtask

    task automatic init_tables();
        set_op(0, 0, 32'h20, M_R);  set_op(1, 0, 32'h21, M_R);  set_op(2, 0, 32'h22, M_R);
        set_op(3, 0, 32'h23, M_R);  set_op(4, 0, 32'h24, M_R);  set_op(5, 0, 32'h25, M_R);
        set_op(6, 0, 32'h26, M_R);  set_op(7, 0, 32'h27, M_R);  set_op(8, 0, 32'h2a, M_R);
        set_op(9, 0, 32'h2b, M_R);
        set_op(10, 0, 32'h00, M_RT | M_RD | M_SH); set_op(11, 0, 32'h02, M_RT | M_RD | M_SH);
        set_op(12, 0, 32'h03, M_RT | M_RD | M_SH);
        set_op(13, 0, 32'h04, M_R); set_op(14, 0, 32'h06, M_R); set_op(15, 0, 32'h07, M_R);
        set_op(16, 0, 32'h08, M_RS);
        set_op(17, 1, 32'h2000_0000, M_LO); set_op(18, 1, 32'h2400_0000, M_LO);
        set_op(19, 1, 32'h3000_0000, M_LO); set_op(20, 1, 32'h3400_0000, M_LO);
        set_op(21, 1, 32'h3800_0000, M_LO); set_op(22, 1, 32'h8C00_0000, M_LO);
        set_op(23, 1, 32'hAC00_0000, M_LO); set_op(24, 1, 32'h1000_0000, M_LO);
        set_op(25, 1, 32'h1400_0000, M_LO); set_op(26, 1, 32'h2800_0000, M_LO);
        set_op(27, 1, 32'h2C00_0000, M_LO); set_op(28, 1, 32'h3C00_0000, M_LO);
        set_op(29, 2, 32'h0800_0000, M_LO); set_op(30, 2, 32'h0C00_0000, M_LO);
        set_op(31, 0, 32'h1a, M_RS | M_RT); set_op(32, 0, 32'h1b, M_RS | M_RT);
        set_op(33, 0, 32'h18, M_RS | M_RT); set_op(34, 0, 32'h19, M_RS | M_RT);
        set_op(35, 1, 32'h0401_0000, M_RS | 32'h0000_FFFF);
        set_op(36, 0, 32'h09, M_RS | M_RD | M_SH);
        set_op(37, 1, 32'h9000_0000, M_LO); set_op(38, 1, 32'h9400_0000, M_LO);
        set_op(39, 1, 32'h8000_0000, M_LO); set_op(40, 1, 32'h8400_0000, M_LO);
        set_op(41, 1, 32'hA000_0000, M_LO); set_op(42, 1, 32'hA400_0000, M_LO);
        set_op(43, 0, 32'h0d, 32'h0);       set_op(44, 0, 32'h0c, 32'h0);
        set_op(45, 0, 32'h4200_0018, 32'h0);
        set_op(46, 0, 32'h10, M_RD); set_op(47, 0, 32'h12, M_RD);
        set_op(48, 0, 32'h11, M_RS); set_op(49, 0, 32'h13, M_RS);
        set_op(50, 0, 32'h4000_0000, M_RT | M_RD); set_op(51, 0, 32'h4080_0000, M_RT | M_RD);
        set_op(52, 0, 32'h7000_0020, M_RS | M_RT | M_RD);
        set_op(53, 0, 32'h34, M_RS | M_RT);
    endtask

    function automatic logic [31:0] model_word(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] raw;
        case (cls_t[op])
            0:       raw = {6'd0, rs, rt, rd, sh, 6'd0};
            1:       raw = {6'd0, rs, rt, imm};
            default: raw = {6'd0, tgt};
        endcase
        return fixed_t[op] | (raw & keep_t[op]);
    endfunction

    // Pattern-matching decoder model: one-hot over every op whose fixed bits match
    function automatic logic [63:0] decode_onehot(input logic [31:0] w);
        logic [63:0] oh = '0;
        for (int i = 0; i < 54; i++)
            if ((w & ~keep_t[i]) == fixed_t[i]) oh[i] = 1'b1;
        return oh;
    endfunction

    // Scoreboard: every word IMEM takes must be the next expected one
    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", 64'(bus_a.out_valid), 64'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("instr", 64'(bus_a.out_instr), 64'(e.instr));
                chk("addr", 64'(bus_a.out_addr), 64'(e.addr));
                chk("decode_onehot", decode_onehot(bus_a.out_instr), 64'd1 << e.op);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_a(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic clr);
        int  waited = 0;
        bit  done = 0;
        bus_a.in_valid = 1'b1; bus_a.in_op = 6'(op); bus_a.in_rs = rs; bus_a.in_rt = rt;
        bus_a.in_rd = rd; bus_a.in_shamt = sh; bus_a.in_imm = imm; bus_a.in_target = tgt;
        bus_a.addr_clr = clr;
        while (!done) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                done = 1;
                if (op < 54) begin
                    exp_t e;
                    logic [31:0] tag;
                    tag = clr ? 32'd0 : m_addr;
                    e.instr = model_word(op, rs, rt, rd, sh, imm, tgt);
                    e.addr = tag; e.op = op;
                    expq.push_back(e);
                    m_addr = tag + 32'd4;
                end else begin
                    if (!m_err) m_err_id = 6'(op);
                    m_err = 1'b1;
                end
            end else if (waited >= 50) begin
                chk("accept_timeout", 64'(bus_a.in_ready), 64'd1);
                done = 1;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited >= 2) bus_a.out_ready = 1'b1;
            end
        end
        bus_a.in_valid = 1'b0;
        bus_a.addr_clr = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        bus_a.out_ready = 1'b1;
        while ((expq.size() != 0 || bus_a.out_valid) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) chk("drain_timeout", 64'(bus_a.out_valid), 64'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        expq.delete(); m_addr = 32'd0; m_err = 1'b0; m_err_id = 6'd0; b_exp = 12;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_b(input int op, input logic clr);
        bus_b.in_valid = 1'b1; bus_b.in_op = 6'(op); bus_b.addr_clr = clr;
        @(negedge clk);
        chk("b_ready", 64'(bus_b.in_ready), 64'd1);
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0; bus_b.addr_clr = 1'b0;
        if (clr) b_exp = 12;
        chk("b_valid", 64'(bus_b.out_valid), 64'd1);
        chk("b_addr", 64'(bus_b.out_addr), 64'(b_exp));
        chk("b_instr", 64'(bus_b.out_instr),
            64'(model_word(op, bus_b.in_rs, bus_b.in_rt, bus_b.in_rd, bus_b.in_shamt,
                           bus_b.in_imm, bus_b.in_target)));
        b_exp = (b_exp + 4) % 16;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        init_tables();
        rst = 1'b1;
        m_addr = 32'd0; m_err = 1'b0; m_err_id = 6'd0; b_exp = 12;
        bus_a.in_valid = 0; bus_a.in_op = 0; bus_a.in_rs = 0; bus_a.in_rt = 0; bus_a.in_rd = 0;
        bus_a.in_shamt = 0; bus_a.in_imm = 0; bus_a.in_target = 0; bus_a.addr_clr = 0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 0; bus_b.in_op = 0; bus_b.in_rs = 5'd7; bus_b.in_rt = 5'd9;
        bus_b.in_rd = 5'd11; bus_b.in_shamt = 5'd2; bus_b.in_imm = 16'h1234;
        bus_b.in_target = 26'h0ABCDEF; bus_b.addr_clr = 0; bus_b.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_out_instr", 64'(bus_a.out_instr), 64'd0);
        chk("rst_out_addr", 64'(bus_a.out_addr), 64'd0);
        chk("rst_err_op", 64'(bus_a.err_op), 64'd0);
        chk("rst_err_op_id", 64'(bus_a.err_op_id), 64'd0);
        chk("rst_b_out_addr", 64'(bus_b.out_addr), 64'd12);
        rst = 1'b0;
        @(posedge clk); #1;

        // Illegal ops: consumed, flagged, first id kept, counter untouched
        send_a(60, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("err_op_set", 64'(bus_a.err_op), 64'(m_err));
        chk("err_op_id_first", 64'(bus_a.err_op_id), 64'(m_err_id));
        chk("illegal_no_valid", 64'(bus_a.out_valid), 64'd0);
        send_a(63, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("err_op_id_held", 64'(bus_a.err_op_id), 64'(m_err_id));

        // addu: one-cycle latency at address 0
        send_a(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("addu_latency_valid", 64'(bus_a.out_valid), 64'd1);
        chk("addu_word", 64'(bus_a.out_instr), 64'h0022_1821);
        chk("addu_addr", 64'(bus_a.out_addr), 64'd0);

        // lw / j / eret
        send_a(22, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
        chk("lw_word", 64'(bus_a.out_instr), 64'h8FA8_0004);
        send_a(29, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 1'b0);
        chk("j_word", 64'(bus_a.out_instr), 64'h0810_0000);
        send_a(45, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
        chk("eret_word", 64'(bus_a.out_instr), 64'h4200_0018);
        drain_a();

        // Backpressure: queue fills at two, head held while stalled, strict order
        pulse_rst();
        bus_a.out_ready = 1'b0;
        send_a(0, 5'd4, 5'd5, 5'd6, 5'd1, 16'd0, 26'd0, 1'b0);
        send_a(18, 5'd7, 5'd8, 5'd0, 5'd0, 16'hBEEF, 26'd0, 1'b0);
        chk("full_in_ready", 64'(bus_a.in_ready), 64'd0);
        chk("full_out_valid", 64'(bus_a.out_valid), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_instr", 64'(bus_a.out_instr), 64'(expq[0].instr));
            chk("stall_addr", 64'(bus_a.out_addr), 64'(expq[0].addr));
            chk("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus_a.out_ready = 1'b1;
        send_a(10, 5'd9, 5'd10, 5'd11, 5'd12, 16'd0, 26'd0, 1'b0);

        // addr_clr with a push, then a plain clear before another push
        send_a(5, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b1);
        send_a(6, 5'd2, 5'd2, 5'd2, 5'd0, 16'd0, 26'd0, 1'b0);
        drain_a();
        bus_a.addr_clr = 1'b1;
        @(posedge clk); #1;
        bus_a.addr_clr = 1'b0;
        m_addr = 32'd0;
        send_a(7, 5'd3, 5'd3, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        drain_a();

        // Narrow counter: 12 -> wrap to 0 -> 4, clear -> 12 -> 0
        send_b(1, 1'b0);
        send_b(22, 1'b0);
        send_b(29, 1'b0);
        send_b(52, 1'b1);
        send_b(50, 1'b0);

        // Round trip over every op with random fields and random backpressure
        pulse_rst();
        for (int op = 0; op < 54; op++) begin
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            send_a(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 26'($urandom), 1'b0);
        end
        drain_a();

        // Reset during a stall drops the queue immediately
        bus_a.out_ready = 1'b0;
        send_a(2, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        send_a(3, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 1'b0);
        #2;
        rst = 1'b1;
        expq.delete(); m_addr = 32'd0; m_err = 1'b0; m_err_id = 6'd0;
        #1;
        chk("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus_a.in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b1;
        send_a(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        chk("post_rst_addr", 64'(bus_a.out_addr), 64'd0);
        drain_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
